// File: rtl/dmem_port_arbiter.sv
// Shares the single data_memory port between the CPU load/store path and a debug/loader port.
// Round-robin arbitration with an optional DBG lock bounded by a forced CPU slot every MAX_LOCK cycles.
module dmem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req_in,
    input  logic          cpu_we_in,
    input  logic [AW-1:0] cpu_addr_in,
    input  logic [DW-1:0] cpu_wdata_in,
    input  logic [1:0]    cpu_size_in,
    output logic          cpu_gnt_out,
    output logic          cpu_rvalid_out,
    output logic [DW-1:0] cpu_rdata_out,
    output logic          cpu_stall_out,
    input  logic          dbg_req_in,
    input  logic          dbg_we_in,
    input  logic [AW-1:0] dbg_addr_in,
    input  logic [DW-1:0] dbg_wdata_in,
    input  logic [1:0]    dbg_size_in,
    input  logic          dbg_lock_in,
    output logic          dbg_gnt_out,
    output logic          dbg_rvalid_out,
    output logic [DW-1:0] dbg_rdata_out,
    output logic [AW-1:0] mem_addr_out,
    output logic          mem_re_out,
    output logic          mem_we_out,
    output logic [DW-1:0] mem_wdata_out,
    output logic [1:0]    mem_size_out,
    input  logic [DW-1:0] mem_rdata_in
);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_DBG  = 1'b1;
    localparam logic [7:0] HOLD_MAX = 8'(MAX_LOCK);

    lock_state_t lock_state;
    logic [7:0]  hold_cnt;
    logic        last_owner;
    logic        rd_vld_p1;
    logic        rd_own_p1;

    logic        lock_active;
    logic        cpu_gnt;
    logic        dbg_gnt;
    logic        forced_cpu;
    logic        rd_issue;

    assign lock_active = (lock_state == LOCKED);

    always_comb begin
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        forced_cpu = 1'b0;
        if (!reset) begin
            if (cpu_req_in && dbg_req_in) begin
                if (lock_active && (hold_cnt < HOLD_MAX)) begin
                    dbg_gnt = 1'b1;
                end else if (lock_active) begin
                    cpu_gnt    = 1'b1;
                    forced_cpu = 1'b1;
                end else if (last_owner == OWN_DBG) begin
                    cpu_gnt = 1'b1;
                end else begin
                    dbg_gnt = 1'b1;
                end
            end else begin
                cpu_gnt = cpu_req_in;
                dbg_gnt = dbg_req_in;
            end
        end
    end

    assign rd_issue = (cpu_gnt & ~cpu_we_in) | (dbg_gnt & ~dbg_we_in);

    // Stage p0 -> p1: read tag captured at issue, consumed when memory returns data
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_state <= UNLOCKED;
            hold_cnt   <= 8'd0;
            last_owner <= OWN_DBG;
            rd_vld_p1  <= 1'b0;
            rd_own_p1  <= OWN_CPU;
        end else begin
            rd_vld_p1 <= rd_issue;
            rd_own_p1 <= dbg_gnt ? OWN_DBG : OWN_CPU;
            if (cpu_gnt || dbg_gnt) begin
                last_owner <= dbg_gnt ? OWN_DBG : OWN_CPU;
            end
            case (lock_state)
                UNLOCKED: begin
                    // The grant that takes the lock counts as the first held cycle.
                    if (dbg_gnt && dbg_lock_in) begin
                        lock_state <= LOCKED;
                        hold_cnt   <= 8'd1;
                    end else begin
                        hold_cnt <= 8'd0;
                    end
                end
                LOCKED: begin
                    if (!dbg_lock_in || !dbg_req_in) begin
                        lock_state <= UNLOCKED;
                        hold_cnt   <= 8'd0;
                    end else if (forced_cpu) begin
                        hold_cnt <= 8'd0;
                    end else if (dbg_gnt && (hold_cnt < HOLD_MAX)) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    lock_state <= UNLOCKED;
                    hold_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign cpu_gnt_out    = cpu_gnt;
    assign dbg_gnt_out    = dbg_gnt;
    assign cpu_rvalid_out = ~reset & rd_vld_p1 & (rd_own_p1 == OWN_CPU);
    assign dbg_rvalid_out = ~reset & rd_vld_p1 & (rd_own_p1 == OWN_DBG);
    assign cpu_rdata_out  = cpu_rvalid_out ? mem_rdata_in : '0;
    assign dbg_rdata_out  = dbg_rvalid_out ? mem_rdata_in : '0;

    // A CPU read stalls through its issue cycle and releases when rvalid arrives.
    assign cpu_stall_out = (cpu_req_in & ~cpu_gnt) | (cpu_gnt & ~cpu_we_in);

    assign mem_addr_out  = dbg_gnt ? dbg_addr_in  : cpu_addr_in;
    assign mem_wdata_out = dbg_gnt ? dbg_wdata_in : cpu_wdata_in;
    assign mem_size_out  = dbg_gnt ? dbg_size_in  : cpu_size_in;
    assign mem_re_out    = rd_issue;
    assign mem_we_out    = (cpu_gnt & cpu_we_in) | (dbg_gnt & dbg_we_in);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, hand sequences and random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_dmem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_LOCK = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req_in, cpu_we_in;
    logic [AW-1:0] cpu_addr_in;
    logic [DW-1:0] cpu_wdata_in;
    logic [1:0]    cpu_size_in;
    logic          cpu_gnt_out, cpu_rvalid_out, cpu_stall_out;
    logic [DW-1:0] cpu_rdata_out;
    logic          dbg_req_in, dbg_we_in, dbg_lock_in;
    logic [AW-1:0] dbg_addr_in;
    logic [DW-1:0] dbg_wdata_in;
    logic [1:0]    dbg_size_in;
    logic          dbg_gnt_out, dbg_rvalid_out;
    logic [DW-1:0] dbg_rdata_out;
    logic [AW-1:0] mem_addr_out;
    logic          mem_re_out, mem_we_out;
    logic [DW-1:0] mem_wdata_out;
    logic [1:0]    mem_size_out;
    logic [DW-1:0] mem_rdata_in;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clock(clock), .reset(reset),
        .cpu_req_in(cpu_req_in), .cpu_we_in(cpu_we_in), .cpu_addr_in(cpu_addr_in),
        .cpu_wdata_in(cpu_wdata_in), .cpu_size_in(cpu_size_in),
        .cpu_gnt_out(cpu_gnt_out), .cpu_rvalid_out(cpu_rvalid_out),
        .cpu_rdata_out(cpu_rdata_out), .cpu_stall_out(cpu_stall_out),
        .dbg_req_in(dbg_req_in), .dbg_we_in(dbg_we_in), .dbg_addr_in(dbg_addr_in),
        .dbg_wdata_in(dbg_wdata_in), .dbg_size_in(dbg_size_in), .dbg_lock_in(dbg_lock_in),
        .dbg_gnt_out(dbg_gnt_out), .dbg_rvalid_out(dbg_rvalid_out),
        .dbg_rdata_out(dbg_rdata_out),
        .mem_addr_out(mem_addr_out), .mem_re_out(mem_re_out), .mem_we_out(mem_we_out),
        .mem_wdata_out(mem_wdata_out), .mem_size_out(mem_size_out),
        .mem_rdata_in(mem_rdata_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, creq, cwe, dreq, dwe, dlock;
        logic [31:0] rdata;
        logic        chk;
        logic        e_cg, e_dg, e_crv, e_drv, e_st;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: who was served last, lock status, cycles held, and the read in flight.
    bit m_locked   = 1'b0;
    bit m_last_dbg = 1'b1;
    int m_hold     = 0;
    int m_rd       = -1;   // -1 none, 0 CPU read in flight, 1 DBG read in flight
    logic g_c, g_d;

    function automatic vec_t mk(input logic rst, creq, cwe, dreq, dwe, dlock,
                                input logic [31:0] rdata, input logic chk,
                                input logic e_cg, e_dg, e_crv, e_drv, e_st);
        vec_t t;
        t.rst = rst; t.creq = creq; t.cwe = cwe; t.dreq = dreq; t.dwe = dwe; t.dlock = dlock;
        t.rdata = rdata; t.chk = chk;
        t.e_cg = e_cg; t.e_dg = e_dg; t.e_crv = e_crv; t.e_drv = e_drv; t.e_st = e_st;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        logic [31:0] e_addr, e_wdata, e_crd, e_drd;
        logic [1:0]  e_size;
        logic        e_crv, e_drv;
        reset = t.rst; cpu_req_in = t.creq; cpu_we_in = t.cwe;
        dbg_req_in = t.dreq; dbg_we_in = t.dwe; dbg_lock_in = t.dlock;
        mem_rdata_in = t.rdata;
        g_c = 1'b0; g_d = 1'b0;
        if (!t.rst) begin
            if (t.creq && t.dreq) begin
                if (m_locked) begin
                    if (m_hold < MAX_LOCK) g_d = 1'b1; else g_c = 1'b1;
                end else if (m_last_dbg) g_c = 1'b1;
                else g_d = 1'b1;
            end else begin
                g_c = t.creq; g_d = t.dreq;
            end
        end
        e_addr  = g_d ? dbg_addr_in  : cpu_addr_in;
        e_wdata = g_d ? dbg_wdata_in : cpu_wdata_in;
        e_size  = g_d ? dbg_size_in  : cpu_size_in;
        e_crv   = !t.rst && (m_rd == 0);
        e_drv   = !t.rst && (m_rd == 1);
        e_crd   = e_crv ? t.rdata : 32'h0;
        e_drd   = e_drv ? t.rdata : 32'h0;
        #1;
        chk({tag, "/cpu_gnt"}, 64'(cpu_gnt_out), 64'(g_c));
        chk({tag, "/dbg_gnt"}, 64'(dbg_gnt_out), 64'(g_d));
        chk({tag, "/mem_re"}, 64'(mem_re_out), 64'((g_c & ~t.cwe) | (g_d & ~t.dwe)));
        chk({tag, "/mem_we"}, 64'(mem_we_out), 64'((g_c & t.cwe) | (g_d & t.dwe)));
        chk({tag, "/mem_addr"}, 64'(mem_addr_out), 64'(e_addr));
        chk({tag, "/mem_wdata"}, 64'(mem_wdata_out), 64'(e_wdata));
        chk({tag, "/mem_size"}, 64'(mem_size_out), 64'(e_size));
        chk({tag, "/cpu_rvalid"}, 64'(cpu_rvalid_out), 64'(e_crv));
        chk({tag, "/dbg_rvalid"}, 64'(dbg_rvalid_out), 64'(e_drv));
        chk({tag, "/cpu_rdata"}, 64'(cpu_rdata_out), 64'(e_crd));
        chk({tag, "/dbg_rdata"}, 64'(dbg_rdata_out), 64'(e_drd));
        chk({tag, "/cpu_stall"}, 64'(cpu_stall_out),
            64'((t.creq & ~g_c) | (g_c & ~t.cwe)));
        if (t.chk) begin
            chk({tag, "/tbl_cpu_gnt"}, 64'(cpu_gnt_out), 64'(t.e_cg));
            chk({tag, "/tbl_dbg_gnt"}, 64'(dbg_gnt_out), 64'(t.e_dg));
            chk({tag, "/tbl_cpu_rvalid"}, 64'(cpu_rvalid_out), 64'(t.e_crv));
            chk({tag, "/tbl_dbg_rvalid"}, 64'(dbg_rvalid_out), 64'(t.e_drv));
            chk({tag, "/tbl_cpu_stall"}, 64'(cpu_stall_out), 64'(t.e_st));
        end
    endtask

    task automatic advance();
        bit nl;
        @(posedge clock);
        if (reset) begin
            m_locked = 1'b0; m_hold = 0; m_last_dbg = 1'b1; m_rd = -1;
        end else begin
            nl = m_locked ? (dbg_lock_in && dbg_req_in) : (g_d && dbg_lock_in);
            if (!nl) m_hold = 0;
            else if (!m_locked) m_hold = 1;
            else if (g_c) m_hold = 0;
            else if (g_d && m_hold < MAX_LOCK) m_hold = m_hold + 1;
            m_rd = (g_c && !cpu_we_in) ? 0 : ((g_d && !dbg_we_in) ? 1 : -1);
            if (g_c || g_d) m_last_dbg = g_d;
            m_locked = nl;
        end
        @(negedge clock);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t r;
        cpu_addr_in = 32'h10; cpu_wdata_in = 32'hC0C0_0001; cpu_size_in = 2'b10;
        dbg_addr_in = 32'h200; dbg_wdata_in = 32'hDB00_0002; dbg_size_in = 2'b01;

        // Reset with both requesting, then a lone CPU read returning 0xDEADBEEF.
        tbl.push_back(mk(1, 1,0, 1,0,0, 32'h0, 1, 0,0,0,0,1));
        tbl.push_back(mk(0, 1,0, 0,0,0, 32'h0, 1, 1,0,0,0,1));
        tbl.push_back(mk(0, 0,0, 0,0,0, 32'hDEADBEEF, 1, 0,0,1,0,0));
        // Continuous contention without lock alternates starting with CPU.
        tbl.push_back(mk(1, 0,0, 0,0,0, 32'h0, 1, 0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1,1, 1,1,0, 32'h0, 1, (i % 2 == 0), (i % 2 == 1), 0,0, (i % 2 == 1)));
        // Locked DBG writes for 20 cycles: 16 DBG grants, a forced CPU slot, then DBG again.
        tbl.push_back(mk(1, 0,0, 0,0,0, 32'h0, 1, 0,0,0,0,0));
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(0, (i > 0),1, 1,1,1, 32'h0, 1, (i == 16), (i != 16), 0,0, (i > 0 && i != 16)));
        tbl.push_back(mk(0, 0,0, 0,0,0, 32'h0, 1, 0,0,0,0,0));
        // DBG read then CPU read: each rvalid routed to its owner only.
        tbl.push_back(mk(0, 0,0, 1,0,0, 32'h0, 1, 0,1,0,0,0));
        tbl.push_back(mk(0, 1,0, 0,0,0, 32'hAAAA_1111, 1, 1,0,0,1,1));
        tbl.push_back(mk(0, 0,0, 0,0,0, 32'hBBBB_2222, 1, 0,0,1,0,0));
        // Reset the cycle after a CPU read issue drops the read; reset also releases a lock.
        tbl.push_back(mk(0, 1,0, 0,0,0, 32'h0, 1, 1,0,0,0,1));
        tbl.push_back(mk(1, 0,0, 0,0,0, 32'h5555_5555, 1, 0,0,0,0,0));
        tbl.push_back(mk(0, 0,0, 1,1,1, 32'h0, 1, 0,1,0,0,0));
        tbl.push_back(mk(1, 1,1, 1,1,1, 32'h0, 1, 0,0,0,0,1));
        tbl.push_back(mk(0, 1,1, 1,1,1, 32'h0, 1, 1,0,0,0,0));
        tbl.push_back(mk(0, 0,0, 0,0,0, 32'h0, 1, 0,0,0,0,0));

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
            advance();
        end

        // CPU write with full size code passes straight through, no rvalid follows.
        cpu_addr_in = 32'h20; cpu_wdata_in = 32'h12345678; cpu_size_in = 2'b11;
        apply(mk(0, 1,1, 0,0,0, 32'h0, 1, 1,0,0,0,0), "wr");
        chk("wr/mem_we_explicit", 64'(mem_we_out), 64'h1);
        chk("wr/mem_wdata_explicit", 64'(mem_wdata_out), 64'h12345678);
        chk("wr/mem_size_explicit", 64'(mem_size_out), 64'h3);
        chk("wr/mem_addr_explicit", 64'(mem_addr_out), 64'h20);
        advance();
        apply(mk(0, 0,0, 0,0,0, 32'hFFFF_FFFF, 1, 0,0,0,0,0), "wr_after");
        advance();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cpu_addr_in  = $urandom; cpu_wdata_in = $urandom; cpu_size_in = 2'($urandom_range(0, 3));
            dbg_addr_in  = $urandom; dbg_wdata_in = $urandom; dbg_size_in = 2'($urandom_range(0, 3));
            r = mk(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
                   ($urandom_range(0, 9) < 8), 1'($urandom), ($urandom_range(0, 9) < 8),
                   $urandom, 0, 0,0,0,0,0);
            apply(r, $sformatf("rnd%0d", i));
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
